// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding, default widths, one-hot test.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_ERR    = 2'd3
   } apb_state_t;

   localparam int APB_DATA_WIDTH     = 32;
   localparam int APB_ADDRESS_WIDTH  = 32;
   localparam int APB_SLAVE_NUM      = 4;
   localparam int APB_TIMEOUT_CYCLES = 16;
   // Widest select vector is_onehot can judge; callers zero-extend into it.
   localparam int APB_MAX_SLAVES     = 64;

   // True when exactly one bit is set (v & (v-1) clears the lowest set bit).
   function automatic logic is_onehot(input logic [APB_MAX_SLAVES-1:0] v);
      logic [APB_MAX_SLAVES-1:0] one;
      one    = '0;
      one[0] = 1'b1;
      return (v != '0) && ((v & (v - one)) == '0);
   endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path mux: picks PRDATA/PREADY/PSLVERR of the slave whose select bit is set.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; an all-zero select yields all-zero outputs (not ready, no error).
module apb_slave_mux
   import apb_pkg::*;
#(
   parameter int SLAVE_NUM  = APB_SLAVE_NUM,
   parameter int DATA_WIDTH = APB_DATA_WIDTH
) (
   input  logic [SLAVE_NUM-1:0]            i_sel,
   input  logic [SLAVE_NUM*DATA_WIDTH-1:0] i_prdata,
   input  logic [SLAVE_NUM-1:0]            i_pready,
   input  logic [SLAVE_NUM-1:0]            i_pslverr,
   output logic [DATA_WIDTH-1:0]           o_prdata,
   output logic                            o_pready,
   output logic                            o_pslverr
);

   // AND-OR select: unselected slaves contribute nothing, whatever they drive.
   always_comb begin
      o_prdata  = '0;
      o_pready  = 1'b0;
      o_pslverr = 1'b0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         if (i_sel[i]) begin
            o_prdata  = o_prdata | i_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            o_pready  = o_pready | i_pready[i];
            o_pslverr = o_pslverr | i_pslverr[i];
         end
      end
   end

endmodule

// File: rtl/apb_master_mux.sv
// APB master for SLAVE_NUM slaves: one-hot PSEL, back-to-back transfers, invalid-select rejection.
// Latency: zero-wait transfer = request edge -> SETUP -> ACCESS -> DONE (3 cycles); bad select -> DONE in 2.
// Backpressure: PREADY stretches ACCESS; with APB_TIMEOUT_EN defined a stall aborts after TIMEOUT_CYCLES waits.
module apb_master_mux
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int ADDRESS_WIDTH  = APB_ADDRESS_WIDTH,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int SLAVE_NUM      = APB_SLAVE_NUM,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
   input  logic                            PCLK,
   input  logic                            PRESET,
   input  logic                            TRANSFER_FLAG,
   input  logic                            READ1_WRITE0,
   input  logic [ADDRESS_WIDTH-1:0]        APB_Address,
   input  logic [DATA_WIDTH-1:0]           APB_writeData,
   input  logic [STRB_WIDTH-1:0]           IN_STRB,
   input  logic [SLAVE_NUM-1:0]            Slave_Select,
   output logic                            REQ_ACCEPT,
   output logic                            DONE,
   output logic [DATA_WIDTH-1:0]           APB_readData,
   output logic                            OUT_SLVERR,
   output logic                            OUT_TIMEOUT,
   output logic [ADDRESS_WIDTH-1:0]        PADDR,
   output logic [DATA_WIDTH-1:0]           PWDATA,
   output logic [STRB_WIDTH-1:0]           PSTRB,
   output logic                            PWRITE,
   output logic                            PENABLE,
   output logic [SLAVE_NUM-1:0]            PSEL,
   input  logic [SLAVE_NUM*DATA_WIDTH-1:0] PRDATA,
   input  logic [SLAVE_NUM-1:0]            PREADY,
   input  logic [SLAVE_NUM-1:0]            PSLVERR
);

   if (SLAVE_NUM < 1 || SLAVE_NUM > APB_MAX_SLAVES || TIMEOUT_CYCLES < 1 ||
       (DATA_WIDTH % 8) != 0 || STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_params
      $error("apb_master_mux: illegal parameter combination");
   end

   apb_state_t                r_state, w_next;
   logic [ADDRESS_WIDTH-1:0]  r_addr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [STRB_WIDTH-1:0]     r_strb;
   logic                      r_write;
   logic [SLAVE_NUM-1:0]      r_sel;
   logic                      r_req_accept, r_done, r_slverr;
   logic [DATA_WIDTH-1:0]     r_rdata;
   logic [APB_MAX_SLAVES-1:0] w_sel_ext;
   logic                      w_sel_onehot;
   logic                      w_capture, w_complete, w_abort, w_err_done;
   logic [DATA_WIDTH-1:0]     w_rdata;
   logic                      w_ready, w_slverr;

   // Zero-extend the requested select so the package one-hot test can judge it.
   always_comb begin
      w_sel_ext                = '0;
      w_sel_ext[SLAVE_NUM-1:0] = Slave_Select;
      w_sel_onehot             = is_onehot(w_sel_ext);
   end

   apb_slave_mux #(
      .SLAVE_NUM (SLAVE_NUM),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_slave_mux (
      .i_sel    (r_sel),
      .i_prdata (PRDATA),
      .i_pready (PREADY),
      .i_pslverr(PSLVERR),
      .o_prdata (w_rdata),
      .o_pready (w_ready),
      .o_pslverr(w_slverr)
   );

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_to_cnt;
   logic             w_to_hit;
   logic             r_timeout;

   // The wait about to be counted is the one that reaches the limit.
   assign w_to_hit = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Stall counter: cleared while in SETUP (entry to ACCESS), counts ACCESS cycles without PREADY.
   always_ff @(posedge PCLK) begin
      if (PRESET)
         r_to_cnt <= '0;
      else if (r_state == ST_SETUP)
         r_to_cnt <= '0;
      else if (r_state == ST_ACCESS && !w_ready)
         r_to_cnt <= r_to_cnt + CNT_W'(1);
   end

   // Timeout flag pulses alongside DONE for an aborted transfer.
   always_ff @(posedge PCLK) begin
      if (PRESET)
         r_timeout <= 1'b0;
      else
         r_timeout <= w_abort;
   end

   assign OUT_TIMEOUT = r_timeout;
`else
   assign OUT_TIMEOUT = 1'b0;
`endif

   // Next-state logic; a completing ACCESS may capture the next request directly.
   always_comb begin
      w_next     = r_state;
      w_capture  = 1'b0;
      w_complete = 1'b0;
      w_abort    = 1'b0;
      w_err_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (TRANSFER_FLAG) begin
               w_capture = 1'b1;
               w_next    = w_sel_onehot ? ST_SETUP : ST_ERR;
            end
         end
         ST_SETUP: w_next = ST_ACCESS;
         ST_ACCESS: begin
            // PREADY is tested first so a ready on the limit edge completes normally.
            if (w_ready) begin
               w_complete = 1'b1;
               if (TRANSFER_FLAG) begin
                  w_capture = 1'b1;
                  w_next    = w_sel_onehot ? ST_SETUP : ST_ERR;
               end else begin
                  w_next = ST_IDLE;
               end
            end
`ifdef APB_TIMEOUT_EN
            else if (w_to_hit) begin
               w_abort = 1'b1;
               w_next  = ST_IDLE;
            end
`endif
         end
         ST_ERR: begin
            w_err_done = 1'b1;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge PCLK) begin
      if (PRESET)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // Request capture; reads carry zero strobes and zero write data onto the bus.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
         r_write <= 1'b0;
         r_sel   <= '0;
      end else if (w_capture) begin
         r_addr  <= APB_Address;
         r_wdata <= READ1_WRITE0 ? '0 : APB_writeData;
         r_strb  <= READ1_WRITE0 ? '0 : IN_STRB;
         r_write <= !READ1_WRITE0;
         r_sel   <= Slave_Select;
      end
   end

   // Completion pulses and read-data hold register.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_req_accept <= 1'b0;
         r_done       <= 1'b0;
         r_slverr     <= 1'b0;
         r_rdata      <= '0;
      end else begin
         r_req_accept <= w_capture;
         r_done       <= w_complete | w_abort | w_err_done;
         r_slverr     <= (w_complete & w_slverr) | w_abort | w_err_done;
         if (w_complete && !r_write)
            r_rdata <= w_rdata;
      end
   end

   assign REQ_ACCEPT   = r_req_accept;
   assign DONE         = r_done;
   assign OUT_SLVERR   = r_slverr;
   assign APB_readData = r_rdata;
   assign PADDR        = r_addr;
   assign PWDATA       = r_wdata;
   assign PSTRB        = r_strb;
   assign PWRITE       = r_write;
   assign PENABLE      = (r_state == ST_ACCESS);
   assign PSEL         = (r_state == ST_SETUP || r_state == ST_ACCESS) ? r_sel : '0;

endmodule
